dma_copy_engine: RTL
====================

DMA_COPY_ENGINE -- requirements
Module: dma_copy_engine

Interface
REQ-001 Parameter DATA_WIDTH, 32, data and address width in bits.
REQ-002 Parameter MEMORY_DEPTH, 256, words in the attached data memory.
REQ-003 Parameter COUNT_WIDTH, 9, width of the word-count field; holds 0..MEMORY_DEPTH.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 in_Start  input  1  request a copy; sampled only in IDLE.
REQ-007 in_Abort  input  1  stop the transfer after the current memory cycle.
REQ-008 in_SrcAddr_dw  input  DATA_WIDTH  source byte address; must be word-aligned.
REQ-009 in_DstAddr_dw  input  DATA_WIDTH  destination byte address; must be word-aligned.
REQ-010 in_WordCount  input  COUNT_WIDTH  number of words to copy.
REQ-011 in_ReadData_dw  input  DATA_WIDTH  memory read data; combinational response to o_Address_dw with o_MemRead high.
REQ-012 o_Address_dw  output  DATA_WIDTH  byte address to memory.
REQ-013 o_WriteData_dw  output  DATA_WIDTH  write data to memory.
REQ-014 o_MemRead  output  1  memory read enable.
REQ-015 o_MemWrite  output  1  memory write enable; memory commits on the next rising edge.
REQ-016 o_Busy  output  1  high in READ and WRITE.
REQ-017 o_Done  output  1  one-cycle completion pulse.
REQ-018 o_Error  output  1  misaligned start; sticky until next accepted in_Start.

Function
REQ-019 The FSM SHALL have states IDLE, READ, WRITE and DONE.
REQ-020 IDLE + in_Start: latch addresses and count, clear o_Error; next state is READ, or DONE if count = 0 or either address has bits[1:0] != 0.
REQ-021 On misalignment, set o_Error = 1 and issue no memory access.
REQ-022 READ: o_MemRead = 1, o_Address_dw = current source; capture in_ReadData_dw into the data register at the edge; next state WRITE.
REQ-023 WRITE: o_MemWrite = 1, o_Address_dw = current destination, o_WriteData_dw = data register.
REQ-024 At the WRITE edge: source and destination += 4 (modulo 2^DATA_WIDTH, wrap without error); count -= 1.
REQ-025 From WRITE, next state is DONE if the decremented count = 0 or in_Abort = 1; otherwise READ.
REQ-026 Throughput is 2 cycles per word.
REQ-027 o_Done is asserted in cycle 2N+1 after the accepting edge for N > 0, and 1 cycle after it for N = 0 or error.
REQ-028 In READ, in_Abort = 1 SHALL go to DONE without the pending write; the read has no side effect.
REQ-029 In WRITE, in_Abort = 1 lets the current write complete, then goes to DONE.
REQ-030 DONE: o_Done = 1 for exactly one cycle, then IDLE.
REQ-031 in_Start outside IDLE SHALL be ignored; operands are not re-latched.
REQ-032 o_MemRead and o_MemWrite SHALL never be high in the same cycle; both are 0 in IDLE and DONE.
REQ-033 o_Address_dw and o_WriteData_dw SHALL be 0 whenever both enables are 0.

Reset
REQ-034 When reset = 1 at a rising edge, state = IDLE and every output, address register, count and data register SHALL be 0.
REQ-035 Reset SHALL take priority over in_Start and in_Abort.
REQ-036 Reset mid-transfer SHALL abort with no further memory access and no o_Done pulse.

Structure
REQ-037 A shared package/include SHALL hold the FSM state encoding, the word stride (4) and the alignment mask (2'b00); the processor control reuses them.
REQ-038 The FSM, counters and data register SHALL be implemented inline; no sub-module.
REQ-039 The bench SHALL attach the team's existing data memory block as the responder.

Verification
REQ-040 Memory words 0..3 = 0xA0..0xA3; Start with src 0x00, dst 0x40, count 4 -> words 16..19 = 0xA0..0xA3, o_Done in cycle 9, o_Busy high for cycles 1..8.
REQ-041 Start with count 0 -> o_Done in cycle 1; o_MemRead and o_MemWrite never asserted; o_Error = 0.
REQ-042 Start with src 0x02 -> o_Error = 1, o_Done in cycle 1, no memory access; o_Error clears on the next valid Start.
REQ-043 count 8, in_Abort pulsed during the second WRITE -> exactly 2 words written, o_Done the next cycle.
REQ-044 reset asserted in cycle 3 of a count-4 copy -> all outputs 0 next cycle, only 1 word written, no o_Done.
REQ-045 in_Start pulsed with new operands during a transfer -> ignored; the original copy completes unchanged.

Source files
------------

// File: rtl/dma_copy_engine_pkg.sv
// Shared definitions for the DMA copy engine and any controller that drives it.
// Contents:
//   state_t      - FSM state encoding (IDLE, READ, WRITE, DONE)
//   WORD_STRIDE  - byte increment between consecutive words
//   ALIGN_MASK   - value the low two address bits must hold for a word access
//   is_aligned() - helper that checks the low address bits against ALIGN_MASK
package dma_copy_engine_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_WRITE = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    localparam int         WORD_STRIDE = 4;
    localparam logic [1:0] ALIGN_MASK  = 2'b00;

    function automatic logic is_aligned(input logic [1:0] low_bits);
        return low_bits == ALIGN_MASK;
    endfunction

endpackage

// File: rtl/dma_copy_engine_if.sv
// Memory bus between the DMA copy engine (master) and a word memory (slave).
// Signals:
//   o_Address_dw   - byte address driven by the master
//   o_WriteData_dw - write data driven by the master
//   o_MemRead      - read enable
//   o_MemWrite     - write enable
//   in_ReadData_dw - read data returned by the slave
//
// Bus protocol: there is no valid/ready stall. A read is a single cycle with
// o_MemRead high; the slave answers combinationally on in_ReadData_dw in that
// same cycle. A write is a single cycle with o_MemWrite high; the slave commits
// o_WriteData_dw at o_Address_dw on the next rising edge. The two enables are
// never high together, and address and write data are held at zero whenever
// both enables are low.
interface dma_copy_engine_if #(
    parameter int DATA_WIDTH = 32
);
    logic [DATA_WIDTH-1:0] o_Address_dw;
    logic [DATA_WIDTH-1:0] o_WriteData_dw;
    logic                  o_MemRead;
    logic                  o_MemWrite;
    logic [DATA_WIDTH-1:0] in_ReadData_dw;

    modport master (
        output o_Address_dw,
        output o_WriteData_dw,
        output o_MemRead,
        output o_MemWrite,
        input  in_ReadData_dw
    );

    modport slave (
        input  o_Address_dw,
        input  o_WriteData_dw,
        input  o_MemRead,
        input  o_MemWrite,
        output in_ReadData_dw
    );
endinterface

// File: rtl/dma_copy_engine.sv
// Word-by-word memory-to-memory copy engine. Each word takes one READ cycle
// followed by one WRITE cycle; a one-cycle DONE pulse ends every accepted
// request, including zero-length and misaligned ones.
// Ports:
//   clk, reset      - clock and synchronous active-high reset
//   in_Start        - start request, only looked at in IDLE
//   in_Abort        - stop after the current memory cycle
//   in_SrcAddr_dw   - source byte address (word aligned)
//   in_DstAddr_dw   - destination byte address (word aligned)
//   in_WordCount    - number of words to copy
//   mem             - memory bus (master side)
//   o_Busy          - high while in READ or WRITE
//   o_Done          - one-cycle completion pulse
//   o_Error         - misaligned request; held until the next accepted start
//   fsm_state       - current FSM state for observation
module dma_copy_engine
    import dma_copy_engine_pkg::*;
#(
    parameter int DATA_WIDTH   = 32,
    parameter int MEMORY_DEPTH = 256,
    parameter int COUNT_WIDTH  = 9
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   in_Start,
    input  logic                   in_Abort,
    input  logic [DATA_WIDTH-1:0]  in_SrcAddr_dw,
    input  logic [DATA_WIDTH-1:0]  in_DstAddr_dw,
    input  logic [COUNT_WIDTH-1:0] in_WordCount,
    dma_copy_engine_if.master      mem,
    output logic                   o_Busy,
    output logic                   o_Done,
    output logic                   o_Error,
    output state_t                 fsm_state
);

    // The count field has to be able to express a full-memory copy.
    if (COUNT_WIDTH < $clog2(MEMORY_DEPTH + 1)) begin : g_count_width_check
        $error("COUNT_WIDTH is too narrow to hold MEMORY_DEPTH");
    end

    localparam logic [DATA_WIDTH-1:0]  STRIDE    = DATA_WIDTH'(WORD_STRIDE);
    localparam logic [COUNT_WIDTH-1:0] COUNT_ONE = COUNT_WIDTH'(1);

    state_t                 state_q;
    state_t                 state_d;
    logic [DATA_WIDTH-1:0]  src_q;
    logic [DATA_WIDTH-1:0]  dst_q;
    logic [DATA_WIDTH-1:0]  data_q;
    logic [COUNT_WIDTH-1:0] count_q;
    logic                   error_q;
    logic                   accept;
    logic                   start_bad;

    assign accept    = (state_q == ST_IDLE) && in_Start;
    assign start_bad = !is_aligned(in_SrcAddr_dw[1:0]) || !is_aligned(in_DstAddr_dw[1:0]);

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (in_Start) begin
                    // Zero-length and misaligned requests skip straight to the
                    // completion pulse without touching memory.
                    if (start_bad || (in_WordCount == '0)) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_READ;
                    end
                end
            end
            // An abort during READ drops the fetched word; the read itself
            // has no side effect on memory.
            ST_READ:  state_d = in_Abort ? ST_DONE : ST_WRITE;
            // count_q still holds the pre-decrement value here, so 1 means
            // this write is the last one.
            ST_WRITE: state_d = ((count_q == COUNT_ONE) || in_Abort) ? ST_DONE : ST_READ;
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // Operand, count, data and error registers
    always_ff @(posedge clk) begin
        if (reset) begin
            src_q   <= '0;
            dst_q   <= '0;
            data_q  <= '0;
            count_q <= '0;
            error_q <= 1'b0;
        end else begin
            if (accept) begin
                src_q   <= in_SrcAddr_dw;
                dst_q   <= in_DstAddr_dw;
                count_q <= in_WordCount;
                error_q <= start_bad;
            end
            if (state_q == ST_READ) begin
                data_q <= mem.in_ReadData_dw;
            end
            // Addresses wrap modulo 2^DATA_WIDTH by plain overflow.
            if (state_q == ST_WRITE) begin
                src_q   <= src_q + STRIDE;
                dst_q   <= dst_q + STRIDE;
                count_q <= count_q - COUNT_ONE;
            end
        end
    end

    // Output decode
    always_comb begin
        mem.o_Address_dw   = '0;
        mem.o_WriteData_dw = '0;
        mem.o_MemRead      = 1'b0;
        mem.o_MemWrite     = 1'b0;
        o_Busy             = 1'b0;
        o_Done             = 1'b0;
        case (state_q)
            ST_READ: begin
                mem.o_MemRead    = 1'b1;
                mem.o_Address_dw = src_q;
                o_Busy           = 1'b1;
            end
            ST_WRITE: begin
                mem.o_MemWrite     = 1'b1;
                mem.o_Address_dw   = dst_q;
                mem.o_WriteData_dw = data_q;
                o_Busy             = 1'b1;
            end
            ST_DONE: begin
                o_Done = 1'b1;
            end
            default: begin
            end
        endcase
    end

    assign o_Error   = error_q;
    assign fsm_state = state_q;

endmodule
